// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port between N_REQ request/response
// clients. It runs each granted request through SETUP/ACCESS and bounds ACCESS with a wait-state timeout.
module apb_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0]                 req_write,
  input  logic [N_REQ*PADDR_SIZE-1:0]      req_addr,
  input  logic [N_REQ*PDATA_SIZE-1:0]      req_wdata,
  input  logic [N_REQ*PDATA_SIZE/8-1:0]    req_strb,
  input  logic [N_REQ*3-1:0]               req_prot,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [PDATA_SIZE-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [$clog2(N_REQ)-1:0]         grant_id,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic [2:0]                       PPROT,
  output logic                             PWRITE,
  output logic [PDATA_SIZE/8-1:0]          PSTRB,
  output logic [PADDR_SIZE-1:0]            PADDR,
  output logic [PDATA_SIZE-1:0]            PWDATA,
  input  logic [PDATA_SIZE-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);

  localparam int GID_W  = $clog2(N_REQ);
  localparam int STRB_W = PDATA_SIZE / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [GID_W-1:0]   last_grant;
  logic [GID_W-1:0]   sel;
  logic [CNT_W-1:0]   wait_cnt;
  logic [STRB_W-1:0]  pstrb_r;
  logic               grant;
  logic               cnt_clr;
  logic               cnt_inc;

  // First requesting index strictly after `last`, wrapping around.
  function automatic logic [GID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [GID_W-1:0] last);
    logic [GID_W-1:0] pick;
    logic [GID_W-1:0] idx;
    logic             found;
    int               ii;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      ii  = (int'(last) + k) % N_REQ;
      idx = GID_W'(ii);
      if (!found && v[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  assign sel     = rr_pick(req_valid, last_grant);
  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign PSTRB   = PWRITE ? pstrb_r : '0;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    grant     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_clr   = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          req_ready = N_REQ'(1) << grant_id;
          rsp_rdata = PWRITE ? '0 : PRDATA;
          rsp_err   = PSLVERR;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
          // Slave never answered: complete the request with an error.
          req_ready = N_REQ'(1) << grant_id;
          rsp_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GID_W'(N_REQ - 1);
      grant_id   <= '0;
      wait_cnt   <= '0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      pstrb_r    <= '0;
      PPROT      <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= sel;
        grant_id   <= sel;
        PWRITE     <= req_write[sel];
        PADDR      <= PADDR_SIZE'(req_addr >> (int'(sel) * PADDR_SIZE));
        PWDATA     <= PDATA_SIZE'(req_wdata >> (int'(sel) * PDATA_SIZE));
        pstrb_r    <= STRB_W'(req_strb >> (int'(sel) * STRB_W));
        PPROT      <= 3'(req_prot >> (int'(sel) * 3));
      end
      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule
